// File: rtl/demux1x2_stream.sv
// ----------------------------------------------------------------------------
// demux1x2_stream
//
// Purpose:
//   Steers a single valid/ready input stream into one of two output FIFOs
//   (A or B). The destination is either the explicit `select` input or, when
//   `alt_en` is high, an internal sequencer that alternates A,B,A,B... on every
//   accepted beat (TDM de-interleave). Each output drains independently, so a
//   stalled consumer on one side never blocks reads on the other.
//
// Handshake rule (all three interfaces):
//   A beat transfers on a rising clock edge where valid=1 and ready=1.
//   in_ready is a combinational function of the current destination and the
//   occupancy of that FIFO only; it never depends on in_valid.
//   a_valid/b_valid depend only on FIFO occupancy, never on a_ready/b_ready.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears FIFOs, storage, sequencer)
//   in_valid  input beat present
//   in_ready  input beat accepted this cycle if in_valid=1
//   in_data   input payload
//   select    destination when alt_en=0: 0=A, 1=B
//   alt_en    1 = ignore select and alternate A,B,A,B...
//   a_valid   FIFO A non-empty
//   a_ready   consumer A takes the head beat
//   a_data    FIFO A head entry
//   b_valid   FIFO B non-empty
//   b_ready   consumer B takes the head beat
//   b_data    FIFO B head entry
//   a_count   FIFO A occupancy
//   b_count   FIFO B occupancy
// ----------------------------------------------------------------------------
module demux1x2_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       select,
    input  logic                       alt_en,
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [WIDTH-1:0]           a_data,
    output logic                       b_valid,
    input  logic                       b_ready,
    output logic [WIDTH-1:0]           b_data,
    output logic [$clog2(DEPTH+1)-1:0] a_count,
    output logic [$clog2(DEPTH+1)-1:0] b_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Alternating sequencer state: which FIFO the next accepted beat goes to.
    typedef enum logic {
        NEXT_A = 1'b0,
        NEXT_B = 1'b1
    } seq_t;

    seq_t             seq_q;
    seq_t             seq_d;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    wr_a;
    logic [PW-1:0]    rd_a;
    logic [PW-1:0]    wr_b;
    logic [PW-1:0]    rd_b;
    logic [CW-1:0]    cnt_a;
    logic [CW-1:0]    cnt_b;

    logic             dest;
    logic             full_a;
    logic             full_b;
    logic             accept;
    logic             push_a;
    logic             push_b;
    logic             pop_a;
    logic             pop_b;

    // ------------------------------------------------------------------------
    // Steering and handshake
    // ------------------------------------------------------------------------
    always_comb begin
        full_a   = (cnt_a == CW'(DEPTH));
        full_b   = (cnt_b == CW'(DEPTH));
        dest     = alt_en ? (seq_q == NEXT_B) : select;
        // Only the addressed FIFO can stall the input; a pop in this same
        // cycle does not open room until the count updates on the next edge.
        in_ready = dest ? ~full_b : ~full_a;
        accept   = in_valid & in_ready;
        push_a   = accept & ~dest;
        push_b   = accept & dest;
        pop_a    = a_valid & a_ready;
        pop_b    = b_valid & b_ready;
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= NEXT_A;
        end else begin
            seq_q <= seq_d;
        end
    end

    always_comb begin
        seq_d = seq_q;
        if (!alt_en) begin
            // Parked on A so every alternating session starts with A.
            seq_d = NEXT_A;
        end else if (accept) begin
            seq_d = (seq_q == NEXT_A) ? NEXT_B : NEXT_A;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO A
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_a  <= '0;
            rd_a  <= '0;
            cnt_a <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
            end
        end else begin
            if (push_a) begin
                mem_a[wr_a] <= in_data;
                wr_a        <= wr_a + PW'(1);
            end
            if (pop_a) begin
                rd_a <= rd_a + PW'(1);
            end
            // Push is gated by !full and pop by !empty, so this never wraps.
            cnt_a <= cnt_a + CW'(push_a) - CW'(pop_a);
        end
    end

    // ------------------------------------------------------------------------
    // FIFO B
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_b  <= '0;
            rd_b  <= '0;
            cnt_b <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_b[i] <= '0;
            end
        end else begin
            if (push_b) begin
                mem_b[wr_b] <= in_data;
                wr_b        <= wr_b + PW'(1);
            end
            if (pop_b) begin
                rd_b <= rd_b + PW'(1);
            end
            cnt_b <= cnt_b + CW'(push_b) - CW'(pop_b);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        a_valid = (cnt_a != '0);
        b_valid = (cnt_b != '0);
        a_data  = mem_a[rd_a];
        b_data  = mem_b[rd_b];
        a_count = cnt_a;
        b_count = cnt_b;
    end

endmodule
